// File: rtl/biquad8_coeff_pkg.sv
// Shared constants, FSM encoding and index-to-address mapping for the biquad8 coefficient loader.
package biquad8_coeff_pkg;

    localparam int unsigned NUM_COEFF   = 17;
    localparam int unsigned F_CROSS_IDX = 7;
    localparam int unsigned G_BASE_IDX  = 8;
    localparam int unsigned G_CROSS_IDX = 16;
    localparam int unsigned G_ADR_BASE  = 16;
    localparam int unsigned IDX_BITS    = 5;
    localparam int unsigned ADR_BITS    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // G entries live in a separate datapath address window starting at G_ADR_BASE.
    function automatic logic [ADR_BITS-1:0] idx_to_adr(input logic [IDX_BITS-1:0] idx);
        if (idx >= IDX_BITS'(G_BASE_IDX)) begin
            return ADR_BITS'(idx - IDX_BITS'(G_BASE_IDX) + IDX_BITS'(G_ADR_BASE));
        end
        return ADR_BITS'(idx);
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// Host staging/commit signals and datapath coefficient-load signals of the loader.
interface biquad8_coeff_loader_if
    import biquad8_coeff_pkg::*;
#(
    parameter int unsigned COEFF_BITS = 18
);
    logic                  cfg_wr_i;
    logic [IDX_BITS-1:0]   cfg_idx_i;
    logic [COEFF_BITS-1:0] cfg_dat_i;
    logic                  commit_i;
    logic [1:0]            commit_sel_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  wr_err_o;
    logic [ADR_BITS-1:0]   coeff_adr_o;
    logic                  coeff_wr_o;
    logic                  coeff_update_o;
    logic [COEFF_BITS-1:0] coeff_dat_o;

    modport slave (
        input  cfg_wr_i, cfg_idx_i, cfg_dat_i, commit_i, commit_sel_i,
        output busy_o, done_o, wr_err_o, coeff_adr_o, coeff_wr_o, coeff_update_o, coeff_dat_o
    );

    modport master (
        output cfg_wr_i, cfg_idx_i, cfg_dat_i, commit_i, commit_sel_i,
        input  busy_o, done_o, wr_err_o, coeff_adr_o, coeff_wr_o, coeff_update_o, coeff_dat_o
    );
endinterface

// File: rtl/biquad8_coeff_seq.sv
// Write sequencer: walks staging indices deepest-first and spaces writes HOLD_CYCLES apart.
module biquad8_coeff_seq
    import biquad8_coeff_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                run_i,
    input  logic [1:0]          sel_i,
    output logic                step_c,
    output logic [IDX_BITS-1:0] nxt_idx_c,
    output logic                last_c,
    output logic                wr_o,
    output logic [ADR_BITS-1:0] adr_o
);
    localparam int unsigned HOLD_BITS = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 2;

    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic                 do_g_q, do_g_d;
    logic                 wr_q, wr_d;
    logic [ADR_BITS-1:0]  adr_q, adr_d;
    logic                 end_of_write;
    logic                 final_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
            do_g_q <= 1'b0;
            wr_q   <= 1'b0;
            adr_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            do_g_q <= do_g_d;
            wr_q   <= wr_d;
            adr_q  <= adr_d;
        end
    end

    // F runs 7..0 then hands over to G at 16 when both sets are selected; G ends at 8.
    always_comb begin
        idx_d        = idx_q;
        hold_d       = hold_q;
        do_g_d       = do_g_q;
        step_c       = 1'b0;
        last_c       = 1'b0;
        end_of_write = (hold_q == HOLD_BITS'(HOLD_CYCLES - 1));
        final_write  = (idx_q == IDX_BITS'(G_BASE_IDX)) || ((idx_q == '0) && !do_g_q);

        if (start_i) begin
            idx_d  = sel_i[0] ? IDX_BITS'(F_CROSS_IDX) : IDX_BITS'(G_CROSS_IDX);
            do_g_d = sel_i[1];
            hold_d = '0;
            step_c = 1'b1;
        end else if (run_i) begin
            if (end_of_write) begin
                if (final_write) begin
                    last_c = 1'b1;
                end else begin
                    idx_d  = (idx_q == '0) ? IDX_BITS'(G_CROSS_IDX) : IDX_BITS'(idx_q - 1'b1);
                    hold_d = '0;
                    step_c = 1'b1;
                end
            end else begin
                hold_d = HOLD_BITS'(hold_q + 1'b1);
            end
        end

        wr_d      = step_c;
        adr_d     = step_c ? idx_to_adr(idx_d) : adr_q;
        nxt_idx_c = idx_d;
    end

    assign wr_o  = wr_q;
    assign adr_o = adr_q;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Coefficient loader: host staging file plus commit FSM streaming into the DSP B-cascade.
module biquad8_coeff_loader
    import biquad8_coeff_pkg::*;
#(
    parameter int unsigned COEFF_BITS  = 18,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    biquad8_coeff_loader_if.slave  bus
);
    state_e                state_q, state_d;
    logic [COEFF_BITS-1:0] stage_q [NUM_COEFF];
    logic [COEFF_BITS-1:0] stage_d [NUM_COEFF];
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  upd_q, upd_d;
    logic [COEFF_BITS-1:0] dat_q, dat_d;

    logic                  start_c;
    logic                  run_c;
    logic                  step_c;
    logic                  last_c;
    logic [IDX_BITS-1:0]   nxt_idx_c;
    logic                  seq_wr;
    logic [ADR_BITS-1:0]   seq_adr;

    biquad8_coeff_seq #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_c),
        .run_i     (run_c),
        .sel_i     (bus.commit_sel_i),
        .step_c    (step_c),
        .nxt_idx_c (nxt_idx_c),
        .last_c    (last_c),
        .wr_o      (seq_wr),
        .adr_o     (seq_adr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '{default: '0};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            upd_q   <= upd_d;
            dat_q   <= dat_d;
        end
    end

    // Commits are only accepted from IDLE, so a mid-load commit is silently ignored.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        run_c   = (state_q == ST_LOAD);

        case (state_q)
            ST_IDLE: begin
                if (bus.commit_i && (bus.commit_sel_i != 2'b00)) begin
                    state_d = ST_LOAD;
                    start_c = 1'b1;
                end
            end
            ST_LOAD:   if (last_c) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_UPDATE);
        upd_d  = (state_d == ST_UPDATE);
        done_d = (state_d == ST_DONE);
    end

    // Staging file is frozen while busy; data is fetched in step with each new write address.
    always_comb begin
        stage_d = stage_q;
        err_d   = err_q;
        if (start_c) begin
            err_d = 1'b0;
        end
        if (bus.cfg_wr_i) begin
            if (busy_q || (bus.cfg_idx_i > IDX_BITS'(NUM_COEFF - 1))) begin
                err_d = 1'b1;
            end else begin
                stage_d[bus.cfg_idx_i] = bus.cfg_dat_i;
            end
        end
        dat_d = step_c ? stage_q[nxt_idx_c] : dat_q;
    end

    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.wr_err_o       = err_q;
    assign bus.coeff_adr_o    = seq_adr;
    assign bus.coeff_wr_o     = seq_wr;
    assign bus.coeff_update_o = upd_q;
    assign bus.coeff_dat_o    = dat_q;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader with a B2 shadow-register model of the datapath.
module tb_biquad8_coeff_loader;
    import biquad8_coeff_pkg::*;

    localparam int unsigned CB   = 18;
    localparam int          HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    biquad8_coeff_loader_if #(.COEFF_BITS(CB)) bus();

    biquad8_coeff_loader #(
        .COEFF_BITS  (CB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: writes land in a pending set, the update pulse copies it to B2.
    int          wr_cyc_q [$];
    logic [4:0]  wr_adr_q [$];
    logic [17:0] wr_dat_q [$];
    logic [17:0] b2   [25] = '{default: '0};
    logic [17:0] pend [25] = '{default: '0};
    int          n_upd = 0, upd_cyc = 0, n_done = 0, done_cyc = 0, busy_cnt = 0, hold_err = 0;
    logic [4:0]  prev_adr = '0;
    logic [17:0] prev_dat = '0;

    always @(negedge clk) begin
        if (rst) begin
            pend <= b2;
        end else begin
            if (bus.coeff_wr_o) begin
                wr_cyc_q.push_back(cyc);
                wr_adr_q.push_back(bus.coeff_adr_o);
                wr_dat_q.push_back(bus.coeff_dat_o);
                pend[bus.coeff_adr_o] <= bus.coeff_dat_o;
            end else if (bus.busy_o && (bus.coeff_adr_o != prev_adr || bus.coeff_dat_o != prev_dat)) begin
                hold_err <= hold_err + 1;
            end
            prev_adr <= bus.coeff_adr_o;
            prev_dat <= bus.coeff_dat_o;
            if (bus.coeff_update_o) begin
                n_upd   <= n_upd + 1;
                upd_cyc <= cyc;
                b2      <= pend;
            end
            if (bus.done_o) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (bus.busy_o) busy_cnt <= busy_cnt + 1;
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] base;
        int          n;
        int          upd_off;
        int          done_off;
    } vec_t;

    vec_t        vecs [3];
    logic [17:0] staged [17];
    logic [17:0] exp_b2 [25];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic stage_wr(input logic [4:0] idx, input logic [17:0] val);
        bus.cfg_wr_i  = 1'b1;
        bus.cfg_idx_i = idx;
        bus.cfg_dat_i = val;
        @(posedge clk); #1;
        bus.cfg_wr_i  = 1'b0;
    endtask

    task automatic stage_all(input logic [17:0] base);
        for (int i = 0; i < 17; i++) begin
            staged[i] = base + 18'(i);
            stage_wr(5'(i), staged[i]);
        end
    endtask

    task automatic do_commit(input logic [1:0] sel, output int c0);
        bus.commit_i     = 1'b1;
        bus.commit_sel_i = sel;
        c0 = cyc;
        @(posedge clk); #1;
        bus.commit_i     = 1'b0;
    endtask

    task automatic wait_done(input int nd0, input string nm);
        int k = 0;
        while (n_done == nd0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_done_seen"}, 32'(n_done > nd0), 32'd1);
    endtask

    task automatic apply_exp(input logic [1:0] sel);
        if (sel[0]) for (int i = 0; i < 8; i++) exp_b2[i] = staged[i];
        if (sel[1]) for (int i = 8; i < 17; i++) exp_b2[i + 8] = staged[i];
    endtask

    task automatic check_b2(input string nm);
        for (int a = 0; a < 25; a++) begin
            if (a < 8 || a >= 16) chk($sformatf("%s_b2_%0d", nm, a), 32'(b2[a]), 32'(exp_b2[a]));
        end
    endtask

    task automatic check_load(input string nm, input int w0, input int c0, input logic [1:0] sel,
                              input int n, input int busy0);
        int k = 0;
        chk({nm, "_nwr"}, 32'(wr_adr_q.size() - w0), 32'(n));
        if (sel[0]) begin
            for (int i = 7; i >= 0; i--) begin
                if (w0 + k < wr_adr_q.size()) begin
                    chk($sformatf("%s_adr%0d", nm, k), 32'(wr_adr_q[w0 + k]), 32'(i));
                    chk($sformatf("%s_dat%0d", nm, k), 32'(wr_dat_q[w0 + k]), 32'(staged[i]));
                    chk($sformatf("%s_cyc%0d", nm, k), 32'(wr_cyc_q[w0 + k] - c0), 32'(1 + k * HOLD));
                end
                k++;
            end
        end
        if (sel[1]) begin
            for (int i = 16; i >= 8; i--) begin
                if (w0 + k < wr_adr_q.size()) begin
                    chk($sformatf("%s_adr%0d", nm, k), 32'(wr_adr_q[w0 + k]), 32'(i + 8));
                    chk($sformatf("%s_dat%0d", nm, k), 32'(wr_dat_q[w0 + k]), 32'(staged[i]));
                    chk($sformatf("%s_cyc%0d", nm, k), 32'(wr_cyc_q[w0 + k] - c0), 32'(1 + k * HOLD));
                end
                k++;
            end
        end
        chk({nm, "_upd_off"},  32'(upd_cyc - c0),      32'(n * HOLD + 1));
        chk({nm, "_done_off"}, 32'(done_cyc - c0),     32'(n * HOLD + 2));
        chk({nm, "_busy_len"}, 32'(busy_cnt - busy0),  32'(n * HOLD + 1));
        chk({nm, "_hold"},     32'(hold_err),          32'd0);
        check_b2(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, w0, b0, nd0, u0;

        vecs[0] = '{2'b11, 18'h100, 17, 52, 53};
        vecs[1] = '{2'b01, 18'h200,  8, 25, 26};
        vecs[2] = '{2'b10, 18'h300,  9, 28, 29};
        exp_b2 = '{default: '0};

        bus.cfg_wr_i     = 1'b0;
        bus.cfg_idx_i    = '0;
        bus.cfg_dat_i    = '0;
        bus.commit_i     = 1'b0;
        bus.commit_sel_i = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy_o),         32'd0);
        chk("rst_done",   32'(bus.done_o),         32'd0);
        chk("rst_err",    32'(bus.wr_err_o),       32'd0);
        chk("rst_adr",    32'(bus.coeff_adr_o),    32'd0);
        chk("rst_wr",     32'(bus.coeff_wr_o),     32'd0);
        chk("rst_upd",    32'(bus.coeff_update_o), 32'd0);
        chk("rst_dat",    32'(bus.coeff_dat_o),    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven loads with each set selection.
        for (int v = 0; v < 3; v++) begin
            stage_all(vecs[v].base);
            w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done;
            do_commit(vecs[v].sel, c0);
            wait_done(nd0, $sformatf("vec%0d", v));
            apply_exp(vecs[v].sel);
            chk($sformatf("vec%0d_upd_tab", v),  32'(upd_cyc - c0),  32'(vecs[v].upd_off));
            chk($sformatf("vec%0d_done_tab", v), 32'(done_cyc - c0), 32'(vecs[v].done_off));
            check_load($sformatf("vec%0d", v), w0, c0, vecs[v].sel, vecs[v].n, b0);
            chk($sformatf("vec%0d_err", v), 32'(bus.wr_err_o), 32'd0);
            @(posedge clk); #1;
        end

        // Staging write during a load is dropped and flags an error.
        stage_all(18'h400);
        w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done;
        do_commit(2'b11, c0);
        repeat (2) begin @(posedge clk); #1; end
        stage_wr(5'd3, 18'h3FFFF);
        wait_done(nd0, "busywr");
        chk("busywr_err", 32'(bus.wr_err_o), 32'd1);
        apply_exp(2'b11);
        check_load("busywr", w0, c0, 2'b11, 17, b0);
        @(posedge clk); #1;
        w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done;
        do_commit(2'b01, c0);
        chk("err_clear", 32'(bus.wr_err_o), 32'd0);
        wait_done(nd0, "reload");
        apply_exp(2'b01);
        check_load("reload", w0, c0, 2'b01, 8, b0);
        @(posedge clk); #1;

        // Illegal index, then an empty-selection commit.
        stage_wr(5'd20, 18'h1234);
        chk("badidx_err", 32'(bus.wr_err_o), 32'd1);
        b0 = busy_cnt;
        do_commit(2'b00, c0);
        repeat (5) begin @(posedge clk); #1; end
        chk("sel0_busy", 32'(busy_cnt - b0), 32'd0);
        chk("sel0_err",  32'(bus.wr_err_o), 32'd1);
        w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done;
        do_commit(2'b11, c0);
        wait_done(nd0, "badidx");
        apply_exp(2'b11);
        check_load("badidx", w0, c0, 2'b11, 17, b0);
        chk("badidx_err_clr", 32'(bus.wr_err_o), 32'd0);
        @(posedge clk); #1;

        // A second commit mid-load is ignored.
        stage_all(18'h600);
        w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done; u0 = n_upd;
        do_commit(2'b11, c0);
        repeat (10) begin @(posedge clk); #1; end
        do_commit(2'b01, c1);
        wait_done(nd0, "dbl");
        apply_exp(2'b11);
        check_load("dbl", w0, c0, 2'b11, 17, b0);
        repeat (10) begin @(posedge clk); #1; end
        chk("dbl_total_wr", 32'(wr_adr_q.size() - w0), 32'd17);
        chk("dbl_nupd",     32'(n_upd - u0),           32'd1);

        // Asynchronous reset mid-load aborts without an update pulse.
        stage_all(18'h500);
        u0 = n_upd;
        do_commit(2'b11, c0);
        while (cyc < c0 + 20) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy_o),         32'd0);
        chk("arst_done", 32'(bus.done_o),         32'd0);
        chk("arst_err",  32'(bus.wr_err_o),       32'd0);
        chk("arst_adr",  32'(bus.coeff_adr_o),    32'd0);
        chk("arst_wr",   32'(bus.coeff_wr_o),     32'd0);
        chk("arst_upd",  32'(bus.coeff_update_o), 32'd0);
        chk("arst_dat",  32'(bus.coeff_dat_o),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_nupd", 32'(n_upd - u0), 32'd0);
        check_b2("arst_keep");

        // Staging was cleared by reset, so a fresh load writes zeros.
        for (int i = 0; i < 17; i++) staged[i] = '0;
        w0 = wr_adr_q.size(); b0 = busy_cnt; nd0 = n_done;
        do_commit(2'b11, c0);
        wait_done(nd0, "post_rst");
        apply_exp(2'b11);
        check_load("post_rst", w0, c0, 2'b11, 17, b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
